regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised integer register file for the NPC core with configurable read-port count. It has a hardwired-zero register 0, write-to-read bypass, and a per-register pending-write scoreboard. Decode queries source readiness through it and issue reserves destinations. Writeback writes data and releases the reservation. Sits between IDU (read/issue side) and WBU (write side).

Parameters:
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
DATA_WIDTH, 64, register width in bits
NR_READ, 2, number of read ports (>=1)
CNT_WIDTH, 2, width of per-register pending-write counter; max outstanding writes per register = 2**CNT_WIDTH-1
BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports; 0 = no forwarding

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
wen  input  1  writeback valid
waddr  input  ADDR_WIDTH  writeback destination
wdata  input  DATA_WIDTH  writeback data
raddr  input  NR_READ*ADDR_WIDTH  read indices, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
rdata  output  NR_READ*DATA_WIDTH  read data, same packing
rbusy  output  NR_READ  port i source has an unresolved pending write
issue_valid  input  1  reserve issue_rd for a future write
issue_rd  input  ADDR_WIDTH  destination to reserve
issue_ready  output  1  reservation for issue_rd will be accepted this cycle
flush  input  1  drop all reservations (pipeline flush)

Behaviour:
- Clock clk, reset rst: one clock; reset is synchronous, active-high.
- Reset: every rf entry <= 0, every counter <= 0. rst has priority over wen, issue and flush in the same cycle. Rst mid-operation discards all in-flight reservations. After reset: rdata = 0 on all ports, rbusy = 0, issue_ready = 1.
- Register 0: reads always return 0. Writes to 0 are dropped. Counter 0 is never incremented. issue_rd = 0 is accepted (issue_ready = 1) with no effect.
- Write: at posedge, if wen && waddr != 0 then rf[waddr] <= wdata. Write happens regardless of counter value and of flush.
- Read: combinational, zero latency, per port independent.
  - BYPASS = 1 and wen && waddr == raddr_i && raddr_i != 0: rdata_i = wdata.
  - Otherwise rdata_i = rf[raddr_i].
- Counter update per register r, evaluated at posedge (rst false):
  - inc = issue_valid && issue_ready && issue_rd == r && r != 0 && !flush
  - dec = wen && waddr == r && cnt[r] != 0
  - flush: cnt[r] <= 0 for all r, except cnt[issue_rd] is not set (a same-cycle issue is dropped).
  - inc && dec: cnt unchanged. inc only: cnt+1. dec only: cnt-1.
  - wen to a register with cnt = 0: data written, counter stays 0 (no underflow).
- issue_ready = (issue_rd == 0) || cnt[issue_rd] != max || (wen && waddr == issue_rd). Combinational. When issue_ready = 0 the issue is ignored and the counter is not saturated past max.
- rbusy_i = raddr_i != 0 && cnt[raddr_i] != 0, masked low when BYPASS = 1 && wen && waddr == raddr_i && cnt[raddr_i] == 1. Last pending write is arriving and forwarded.
- With BYPASS = 0, rbusy_i reflects the counter only. The matching write is visible the cycle after wen.
- Multiple ports reading the same index return identical data and busy.
- No internal state other than rf array and counters. No X on outputs after the first reset.

Test Plan:
- Reset/zero: rst 1 cycle, then wen=1 waddr=0 wdata=0xDEAD, raddr0=0 -> rdata0=0 that cycle and next, rbusy0=0; raddr1=7 -> rdata1=0.
- Write/bypass: wen=1 waddr=5 wdata=0x1234, raddr0=5. BYPASS=1 -> rdata0=0x1234 same cycle. BYPASS=0 -> old value same cycle, 0x1234 next cycle.
- Scoreboard: issue rd=3 twice in consecutive cycles -> cnt=2, rbusy on raddr=3. First wen waddr=3 -> rbusy still 1. Second wen (BYPASS=1) -> rbusy=0 during that cycle, 0 after.
- Saturation/simultaneous: CNT_WIDTH=2, issue rd=9 three times -> issue_ready=0 for rd=9 and a 4th issue is ignored. Issue rd=9 with wen waddr=9 same cycle -> issue_ready=1 and cnt stays 3.
- Flush: reserve rd=4 and rd=6, then flush=1 with issue_valid rd=8 and wen waddr=4 wdata=0x55. Next cycle: all rbusy=0, rd=8 not reserved, rf[4]=0x55.
- Reset mid-operation: cnt[10]=2, rf[10]=0xAA. Assert rst together with wen waddr=10 -> next cycle rf[10]=0, rbusy on 10 = 0, issue_ready=1.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Integer register file with hardwired-zero x0, optional write-to-read bypass
// and a per-register pending-write scoreboard used by decode/issue/writeback.
module regfile_scoreboard #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NR_READ    = 2,
    parameter int unsigned CNT_WIDTH  = 2,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wen,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic [NR_READ*ADDR_WIDTH-1:0]    raddr,
    output logic [NR_READ*DATA_WIDTH-1:0]    rdata,
    output logic [NR_READ-1:0]               rbusy,
    input  logic                             issue_valid,
    input  logic [ADDR_WIDTH-1:0]            issue_rd,
    output logic                             issue_ready,
    input  logic                             flush
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0] rf_q  [DEPTH];
    logic [CNT_WIDTH-1:0]  cnt_q [DEPTH];
    logic [CNT_WIDTH-1:0]  cnt_d [DEPTH];
    logic [DEPTH-1:0]      inc_c;
    logic [DEPTH-1:0]      dec_c;
    logic                  wr_en_c;

    // A writeback to x0 is discarded; everything else lands regardless of flush.
    assign wr_en_c = wen && (waddr != '0);

    // Reservation is refused only when the counter is full and no write frees a slot.
    assign issue_ready = (issue_rd == '0)
                      || (cnt_q[issue_rd] != CNT_MAX)
                      || (wen && (waddr == issue_rd));

    // Per-register increment/decrement decode and next counter value.
    always_comb begin
        inc_c = '0;
        dec_c = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            cnt_d[r] = cnt_q[r];
            inc_c[r] = issue_valid && issue_ready && !flush
                    && (issue_rd == ADDR_WIDTH'(r)) && (r != 0);
            dec_c[r] = wen && (waddr == ADDR_WIDTH'(r)) && (cnt_q[r] != '0);
            if (flush) begin
                cnt_d[r] = '0;
            end else if (inc_c[r] && !dec_c[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec_c[r] && !inc_c[r]) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    // Register array storage; reset clears every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                rf_q[r] <= '0;
            end
        end else if (wr_en_c) begin
            rf_q[waddr] <= wdata;
        end
    end

    // Pending-write counters; reset drops all in-flight reservations.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Independent combinational read ports with optional same-cycle forwarding.
    for (genvar i = 0; i < int'(NR_READ); i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra_c;
        logic                  hit_c;
        logic                  fwd_c;

        assign ra_c  = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign hit_c = wen && (waddr == ra_c) && (ra_c != '0);
        assign fwd_c = BYPASS && hit_c;

        assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = (ra_c == '0) ? '0
                                                 : fwd_c        ? wdata
                                                 : rf_q[ra_c];

        // The last outstanding write arriving this cycle is forwarded, so not busy.
        assign rbusy[i] = (ra_c != '0) && (cnt_q[ra_c] != '0)
                       && !(fwd_c && (cnt_q[ra_c] == CNT_ONE));
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default parameters, bypass on).
module tb_regfile_scoreboard;

    logic         clk;
    logic         rst;
    logic         wen;
    logic [4:0]   waddr;
    logic [63:0]  wdata;
    logic [9:0]   raddr;
    logic [127:0] rdata;
    logic [1:0]   rbusy;
    logic         issue_valid;
    logic [4:0]   issue_rd;
    logic         issue_ready;
    logic         flush;

    int total;
    int bad;

    regfile_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr      (raddr),
        .rdata      (rdata),
        .rbusy      (rbusy),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_ready(issue_ready),
        .flush      (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Commit one clock edge, then step off it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; wen = 1'b0; waddr = '0; wdata = '0;
        issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
    endtask

    task automatic test_reset();
        idle();
        set_rd(5'd3, 5'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++; if (rdata !== 128'h0) begin bad++; $display("FAIL reset_rdata got=%h want=%h", rdata, 128'h0); end
        total++; if (rbusy !== 2'b00) begin bad++; $display("FAIL reset_rbusy got=%b want=00", rbusy); end
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_issue_ready got=%b want=1", issue_ready); end
        // Write to x0 is dropped, read of x0 stays zero.
        wen = 1'b1; waddr = 5'd0; wdata = 64'hDEAD;
        set_rd(5'd0, 5'd7);
        #1;
        total++; if (rdata[63:0] !== 64'h0) begin bad++; $display("FAIL x0_same_cycle got=%h want=0", rdata[63:0]); end
        total++; if (rbusy[0] !== 1'b0) begin bad++; $display("FAIL x0_rbusy got=%b want=0", rbusy[0]); end
        total++; if (rdata[127:64] !== 64'h0) begin bad++; $display("FAIL r7_after_reset got=%h want=0", rdata[127:64]); end
        tick();
        wen = 1'b0;
        #1;
        total++; if (rdata[63:0] !== 64'h0) begin bad++; $display("FAIL x0_next_cycle got=%h want=0", rdata[63:0]); end
        // Issue to x0 is accepted and reserves nothing.
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL x0_issue_ready got=%b want=1", issue_ready); end
        tick();
        issue_valid = 1'b0;
        #1;
        total++; if (rbusy[0] !== 1'b0) begin bad++; $display("FAIL x0_issue_no_busy got=%b want=0", rbusy[0]); end
    endtask

    task automatic test_write_bypass();
        idle();
        wen = 1'b1; waddr = 5'd5; wdata = 64'h1234;
        set_rd(5'd5, 5'd6);
        #1;
        total++; if (rdata[63:0] !== 64'h1234) begin bad++; $display("FAIL bypass_same_cycle got=%h want=1234", rdata[63:0]); end
        total++; if (rdata[127:64] !== 64'h0) begin bad++; $display("FAIL bypass_other_port got=%h want=0", rdata[127:64]); end
        tick();
        wen = 1'b0;
        set_rd(5'd5, 5'd5);
        #1;
        total++; if (rdata[63:0] !== 64'h1234) begin bad++; $display("FAIL write_stored got=%h want=1234", rdata[63:0]); end
        total++; if (rdata[127:64] !== 64'h1234) begin bad++; $display("FAIL same_index_port1 got=%h want=1234", rdata[127:64]); end
    endtask

    task automatic test_scoreboard();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        tick();
        issue_valid = 1'b0;
        set_rd(5'd3, 5'd3);
        #1;
        total++; if (rbusy !== 2'b11) begin bad++; $display("FAIL sb_busy_cnt2 got=%b want=11", rbusy); end
        wen = 1'b1; waddr = 5'd3; wdata = 64'h33;
        #1;
        total++; if (rbusy[0] !== 1'b1) begin bad++; $display("FAIL sb_first_wb_busy got=%b want=1", rbusy[0]); end
        tick();
        wdata = 64'h34;
        #1;
        total++; if (rbusy !== 2'b00) begin bad++; $display("FAIL sb_last_wb_masked got=%b want=00", rbusy); end
        total++; if (rdata[63:0] !== 64'h34) begin bad++; $display("FAIL sb_last_wb_fwd got=%h want=34", rdata[63:0]); end
        tick();
        wen = 1'b0;
        #1;
        total++; if (rbusy !== 2'b00) begin bad++; $display("FAIL sb_after_release got=%b want=00", rbusy); end
        total++; if (rdata[63:0] !== 64'h34) begin bad++; $display("FAIL sb_final_data got=%h want=34", rdata[63:0]); end
    endtask

    task automatic test_saturation();
        idle();
        set_rd(5'd9, 5'd0);
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        tick();
        tick();
        #1;
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL sat_ready_full got=%b want=0", issue_ready); end
        tick();  // fourth issue must be ignored
        wen = 1'b1; waddr = 5'd9; wdata = 64'h99;
        #1;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL sat_ready_with_wb got=%b want=1", issue_ready); end
        total++; if (rbusy[0] !== 1'b1) begin bad++; $display("FAIL sat_busy got=%b want=1", rbusy[0]); end
        tick();  // inc and dec together: counter holds at 3
        wen = 1'b0; issue_valid = 1'b0;
        #1;
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL sat_cnt_held got=%b want=0", issue_ready); end
        wen = 1'b1;
        tick();
        tick();
        wen = 1'b0;
        #1;
        total++; if (rbusy[0] !== 1'b1) begin bad++; $display("FAIL sat_one_left got=%b want=1", rbusy[0]); end
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL sat_ready_drained got=%b want=1", issue_ready); end
        wen = 1'b1;
        tick();
        wen = 1'b0;
        #1;
        total++; if (rbusy[0] !== 1'b0) begin bad++; $display("FAIL sat_all_released got=%b want=0", rbusy[0]); end
    endtask

    task automatic test_flush();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd4;
        tick();
        issue_rd = 5'd6;
        tick();
        issue_valid = 1'b0;
        set_rd(5'd4, 5'd6);
        #1;
        total++; if (rbusy !== 2'b11) begin bad++; $display("FAIL flush_pre_busy got=%b want=11", rbusy); end
        flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd8;
        wen = 1'b1; waddr = 5'd4; wdata = 64'h55;
        tick();
        idle();
        #1;
        total++; if (rbusy !== 2'b00) begin bad++; $display("FAIL flush_cleared got=%b want=00", rbusy); end
        total++; if (rdata[63:0] !== 64'h55) begin bad++; $display("FAIL flush_write_kept got=%h want=55", rdata[63:0]); end
        set_rd(5'd8, 5'd8);
        #1;
        total++; if (rbusy !== 2'b00) begin bad++; $display("FAIL flush_issue_dropped got=%b want=00", rbusy); end
    endtask

    task automatic test_reset_mid();
        idle();
        set_rd(5'd10, 5'd0);
        wen = 1'b1; waddr = 5'd10; wdata = 64'hAA;
        tick();
        wen = 1'b0;
        #1;
        total++; if (rbusy[0] !== 1'b0) begin bad++; $display("FAIL no_underflow got=%b want=0", rbusy[0]); end
        total++; if (rdata[63:0] !== 64'hAA) begin bad++; $display("FAIL mid_pre_data got=%h want=aa", rdata[63:0]); end
        issue_valid = 1'b1; issue_rd = 5'd10;
        tick();
        tick();
        issue_valid = 1'b0;
        #1;
        total++; if (rbusy[0] !== 1'b1) begin bad++; $display("FAIL mid_pre_busy got=%b want=1", rbusy[0]); end
        rst = 1'b1; wen = 1'b1; waddr = 5'd10; wdata = 64'h77;
        issue_valid = 1'b1; issue_rd = 5'd10;
        tick();
        idle();
        issue_rd = 5'd10;
        #1;
        total++; if (rdata[63:0] !== 64'h0) begin bad++; $display("FAIL mid_rst_data got=%h want=0", rdata[63:0]); end
        total++; if (rbusy[0] !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", rbusy[0]); end
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b want=1", issue_ready); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        raddr = '0;
        test_reset();
        test_write_bypass();
        test_scoreboard();
        test_saturation();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
